// File: rtl/hilo_unit.sv
// HI/LO register unit: carries HI/LO writes through MEM and WB slots, commits them at WB,
// and forwards the newest in-flight value per half to mfhi/mflo reads in EX.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_wr_en,
    input  logic [1:0]       ex_wr_sel,
    input  logic [WIDTH-1:0] ex_lo_data,
    input  logic [WIDTH-1:0] ex_hi_data,
    input  logic             stall,
    input  logic             flush,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             m_vlo, m_vhi, w_vlo, w_vhi;
    logic [WIDTH-1:0] m_lo, m_hi, w_lo, w_hi;

    // Stall freezes every slot and the architectural pair, and overrides flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vlo <= 1'b0;
            m_vhi <= 1'b0;
            m_lo  <= '0;
            m_hi  <= '0;
            w_vlo <= 1'b0;
            w_vhi <= 1'b0;
            w_lo  <= '0;
            w_hi  <= '0;
            lo    <= '0;
            hi    <= '0;
        end else if (!stall) begin
            m_vlo <= ex_wr_en & ex_wr_sel[0] & ~flush;
            m_vhi <= ex_wr_en & ex_wr_sel[1] & ~flush;
            m_lo  <= ex_lo_data;
            m_hi  <= ex_hi_data;
            w_vlo <= m_vlo;
            w_vhi <= m_vhi;
            w_lo  <= m_lo;
            w_hi  <= m_hi;
            if (w_vlo) lo <= w_lo;
            if (w_vhi) hi <= w_hi;
        end
    end

    // Each half is forwarded independently, so a partial write never shadows the other half.
    always_comb begin
        rd_data = '0;
        if (rd_sel) begin
            if (m_vhi)      rd_data = m_hi;
            else if (w_vhi) rd_data = w_hi;
            else            rd_data = hi;
        end else begin
            if (m_vlo)      rd_data = m_lo;
            else if (w_vlo) rd_data = w_lo;
            else            rd_data = lo;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed cases plus randomized traffic
// compared against a queue-based model of the in-flight writes.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wr_en;
    logic [1:0]  ex_wr_sel;
    logic [31:0] ex_lo_data, ex_hi_data;
    logic        stall, flush, rd_sel;
    logic [31:0] rd_data, hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vlo;
        logic        vhi;
        logic [31:0] lo;
        logic [31:0] hi;
    } wr_t;

    // q[0] is the youngest in-flight write; anything older than two non-stalled edges commits.
    wr_t         q[$];
    logic [31:0] ref_hi, ref_lo;
    logic [31:0] rd_lo_now, rd_hi_now;

    hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ex_wr_en(ex_wr_en), .ex_wr_sel(ex_wr_sel),
        .ex_lo_data(ex_lo_data), .ex_hi_data(ex_hi_data), .stall(stall),
        .flush(flush), .rd_sel(rd_sel), .rd_data(rd_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic wr_t bubble();
        wr_t b;
        b.vlo = 1'b0; b.vhi = 1'b0; b.lo = '0; b.hi = '0;
        return b;
    endfunction

    function automatic logic [31:0] model_read(input bit want_hi);
        for (int i = 0; i < q.size(); i++) begin
            if (want_hi && q[i].vhi) return q[i].hi;
            if (!want_hi && q[i].vlo) return q[i].lo;
        end
        return want_hi ? ref_hi : ref_lo;
    endfunction

    task automatic model_edge(input logic r, input logic en, input logic [1:0] sel,
                              input logic [31:0] ld, input logic [31:0] hd,
                              input logic st, input logic fl);
        wr_t w, old;
        if (r) begin
            q.delete();
            q.push_back(bubble());
            q.push_back(bubble());
            ref_hi = '0;
            ref_lo = '0;
        end else if (!st) begin
            w.vlo = en && sel[0] && !fl;
            w.vhi = en && sel[1] && !fl;
            w.lo  = ld;
            w.hi  = hd;
            q.push_front(w);
            old = q.pop_back();
            if (old.vlo) ref_lo = old.lo;
            if (old.vhi) ref_hi = old.hi;
        end
    endtask

    // Applies one cycle of inputs, advances past the edge, then compares all outputs to the model.
    task automatic applyStimulus(input logic r, input logic en, input logic [1:0] sel,
                                 input logic [31:0] ld, input logic [31:0] hd,
                                 input logic st, input logic fl);
        rst = r; ex_wr_en = en; ex_wr_sel = sel; ex_lo_data = ld; ex_hi_data = hd;
        stall = st; flush = fl;
        @(posedge clk);
        #1;
        model_edge(r, en, sel, ld, hd, st, fl);
        rd_sel = 1'b0;
        #1;
        rd_lo_now = rd_data;
        checkOutput("model_rd_lo", rd_data, model_read(1'b0));
        rd_sel = 1'b1;
        #1;
        rd_hi_now = rd_data;
        checkOutput("model_rd_hi", rd_data, model_read(1'b1));
        checkOutput("model_lo", lo, ref_lo);
        checkOutput("model_hi", hi, ref_hi);
    endtask

    task automatic idle(input logic st, input logic fl);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF, 32'hFEED_FACE, st, fl);
    endtask

    initial begin
        q.push_back(bubble());
        q.push_back(bubble());
        ref_hi = '0; ref_lo = '0;
        rd_sel = 1'b0;

        // Reset with a write presented on the inputs.
        applyStimulus(1'b1, 1'b1, 2'b11, 32'h1234, 32'h1234, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b11, 32'h1234, 32'h1234, 1'b1, 1'b1);
        idle(1'b0, 1'b0);
        checkOutput("reset_rd_lo", rd_lo_now, 32'h0);
        checkOutput("reset_rd_hi", rd_hi_now, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_hi", hi, 32'h0);

        // Full write and commit.
        applyStimulus(1'b0, 1'b1, 2'b11, 32'h89AB_CDEF, 32'h0123_4567, 1'b0, 1'b0);
        checkOutput("full_c1_rd_lo", rd_lo_now, 32'h89AB_CDEF);
        checkOutput("full_c1_rd_hi", rd_hi_now, 32'h0123_4567);
        checkOutput("full_c1_lo_old", lo, 32'h0);
        idle(1'b0, 1'b0);
        checkOutput("full_c2_rd_lo", rd_lo_now, 32'h89AB_CDEF);
        checkOutput("full_c2_rd_hi", rd_hi_now, 32'h0123_4567);
        checkOutput("full_c2_lo_old", lo, 32'h0);
        idle(1'b0, 1'b0);
        checkOutput("full_c3_lo", lo, 32'h89AB_CDEF);
        checkOutput("full_c3_hi", hi, 32'h0123_4567);

        // Forward priority from a clean reset.
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h11, 32'h99, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h22, 32'h99, 1'b0, 1'b0);
        checkOutput("prio_rd_lo", rd_lo_now, 32'h22);
        repeat (3) idle(1'b0, 1'b0);
        checkOutput("prio_lo", lo, 32'h22);
        checkOutput("prio_hi", hi, 32'h0);

        // Partial-write merge.
        applyStimulus(1'b0, 1'b1, 2'b11, 32'hBB, 32'hAA, 1'b0, 1'b0);
        repeat (3) idle(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b10, 32'h55, 32'hCC, 1'b0, 1'b0);
        checkOutput("merge_rd_lo", rd_lo_now, 32'hBB);
        checkOutput("merge_rd_hi", rd_hi_now, 32'hCC);
        repeat (3) idle(1'b0, 1'b0);
        checkOutput("merge_lo", lo, 32'hBB);
        checkOutput("merge_hi", hi, 32'hCC);

        // Flushed div write never becomes visible.
        applyStimulus(1'b0, 1'b1, 2'b11, 32'd5, 32'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("flush_rd_lo", rd_lo_now, 32'hBB);
            checkOutput("flush_rd_hi", rd_hi_now, 32'hCC);
            checkOutput("flush_lo", lo, 32'hBB);
            checkOutput("flush_hi", hi, 32'hCC);
            idle(1'b0, 1'b0);
        end

        // Stall for three cycles with an ignored flush in the middle.
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h77, 32'h0, 1'b0, 1'b0);
        checkOutput("stall_c1_rd_lo", rd_lo_now, 32'h77);
        idle(1'b1, 1'b0);
        checkOutput("stall_c2_rd_lo", rd_lo_now, 32'h77);
        idle(1'b1, 1'b1);
        checkOutput("stall_c3_rd_lo", rd_lo_now, 32'h77);
        idle(1'b1, 1'b0);
        checkOutput("stall_c4_rd_lo", rd_lo_now, 32'h77);
        idle(1'b0, 1'b0);
        checkOutput("stall_c5_rd_lo", rd_lo_now, 32'h77);
        checkOutput("stall_c5_lo_old", lo, 32'hBB);
        idle(1'b0, 1'b0);
        checkOutput("stall_c6_lo", lo, 32'h77);
        checkOutput("stall_c6_rd_lo", rd_lo_now, 32'h77);

        // Randomized traffic, including occasional mid-stream resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 29) == 0),
                          1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)),
                          $urandom(), $urandom(),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO register unit for the pipelined MIPS core, the consumer end of the ALU's two-result interface. It captures the ALU's result pair for mult/multu/div/divu (result1 → LO, result2 → HI) and single-word mthi/mtlo writes from the EX stage. These writes travel through MEM and WB pipeline slots and commit to the architectural HI/LO at WB. The block serves mfhi/mflo reads in EX, with full forwarding from in-flight writes so no stall is needed.

## Interface
Parameters:
- `WIDTH`, default 32: data width of HI, LO and all data ports.

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_wr_en` in 1: EX-stage instruction writes HI and/or LO.
- `ex_wr_sel` in 2: bit0 writes LO, bit1 writes HI. Values: `11` for mult/div, `01` for mtlo, `10` for mthi.
- `ex_lo_data` in WIDTH: value for LO (ALU result1, or rs for mtlo).
- `ex_hi_data` in WIDTH: value for HI (ALU result2, or rs for mthi).
- `stall` in 1: freeze all pipeline slots and commit.
- `flush` in 1: discard the EX-stage write (bubble into MEM).
- `rd_sel` in 1: 0 reads LO (mflo), 1 reads HI (mfhi).
- `rd_data` out WIDTH: forwarded read value, combinational.
- `hi` out WIDTH: architectural HI.
- `lo` out WIDTH: architectural LO.

## Operation
- State:
  - MEM slot: `m_vlo`, `m_vhi`, `m_lo`, `m_hi`.
  - WB slot: `w_vlo`, `w_vhi`, `w_lo`, `w_hi`.
  - Architectural `hi`, `lo`.
- Per-half valid bits:
  - `m_vlo` = `ex_wr_en & ex_wr_sel[0]`.
  - `m_vhi` = `ex_wr_en & ex_wr_sel[1]`.
  - `ex_wr_sel=00` with `ex_wr_en=1` is a no-op.
- Each rising edge with `stall=0`:
  - MEM slot ← EX inputs. All valid bits are forced to 0 if `flush=1`.
  - WB slot ← MEM slot.
  - `lo` ← `w_lo` if `w_vlo`; `hi` ← `w_hi` if `w_vhi`.
  - An invalid half leaves its architectural register unchanged.
- Edge with `stall=1`:
  - All slots and architectural registers hold.
  - `flush` is ignored; stall has priority.
- Read forwarding, evaluated independently per half, newest wins:
  1. MEM slot valid for the selected half.
  2. WB slot valid for the selected half.
  3. Architectural register.
- A read in EX never sees the write presented in the same EX cycle. Same-instruction read and write is impossible in MIPS.
- Data is passed unmodified. No arithmetic, no width change.

## Timing
- Reset values: `hi=0`, `lo=0`, all slot data 0, all valid bits 0, so `rd_data=0`. Reset overrides `stall` and `flush`.
- Reset asserted mid-operation discards all in-flight writes on that edge.
- Write latency, with `ex_wr_en=1` presented in cycle N and no stalls:
  - Edge end of N: value in MEM slot; visible on `rd_data` in cycle N+1.
  - Edge end of N+1: value in WB slot.
  - Edge end of N+2: value committed; `hi`/`lo` show it from cycle N+3.
- Back-to-back writes to the same half: the younger write is forwarded first, and architectural state ends with the younger value.
- Partial writes: mthi followed by mflo forwards LO from the older full write or the architectural register, not from the mthi slot.
- Stall cycles add exactly one cycle of latency each. `rd_data` stays stable during a stall if `rd_sel` is stable.
- `rd_data` is combinational from `rd_sel` and the slot/architectural registers, with no dependence on the EX write inputs.

## Test plan
- Reset: hold `rst=1` with `ex_wr_en=1`, `sel=11`, `ex_lo_data=0x1234`. Required: after release `hi=lo=0` and `rd_data=0` for both `rd_sel` values.
- Full write and commit: mult result lo=`0x89ABCDEF`, hi=`0x01234567` in cycle 0. Required:
  - Cycle 1: `rd_sel=0` → `0x89ABCDEF`; `rd_sel=1` → `0x01234567`.
  - Cycle 2: still forwarded.
  - Cycle 3: `lo=0x89ABCDEF`, `hi=0x01234567`.
- Forward priority: cycle 0 mtlo `0x11`, cycle 1 mtlo `0x22`. Required:
  - Cycle 2: `rd_sel=0` → `0x22`.
  - Final `lo=0x22`.
  - `hi` unchanged at 0.
- Partial-write merge: commit hi=`0xAA`, lo=`0xBB`, then mthi `0xCC`. Required: the next cycle's `rd_sel=0` → `0xBB`, `rd_sel=1` → `0xCC`, and final `lo=0xBB`.
- Flush: div write lo=`5`, hi=`3` with `flush=1`. Required: `rd_data` and `hi`/`lo` never show 5 or 3; prior values persist.
- Stall: write lo=`0x77` in cycle 0, then `stall=1` in cycles 1–3 with `flush=1` pulsed in cycle 2. Required:
  - `rd_sel=0` reads `0x77` throughout.
  - `lo=0x77` appears exactly 3 cycles later than the unstalled case (from cycle 6).
  - The write is not lost to the ignored flush.
